// File: rtl/pressed_lvl_in_queue_check_if.sv
// Request/result bundle for the pressed-level queue membership checker.
// hit_idx exists only when PIQ_HIT_IDX_EN is defined.
interface pressed_lvl_in_queue_check_if #(
  parameter int DEPTH  = 4,
  parameter int LVL_W  = 2,
  parameter int TAIL_W = 3,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
);
  // Valid-only protocol, no ready: the checker accepts a request on every
  // rising edge where in_valid=1, and out_valid pulses exactly one cycle later.
  logic                   in_valid;
  logic [LVL_W-1:0]       pressed_lvl;
  logic [DEPTH*LVL_W-1:0] queue;
  logic [TAIL_W-1:0]      tail;
  logic                   pressed_lvl_in_queue;
  logic                   out_valid;
`ifdef PIQ_HIT_IDX_EN
  logic [IDX_W-1:0]       hit_idx;
`endif

  modport master (
    output in_valid, pressed_lvl, queue, tail,
`ifdef PIQ_HIT_IDX_EN
    input  hit_idx,
`endif
    input  pressed_lvl_in_queue, out_valid
  );

  modport slave (
    input  in_valid, pressed_lvl, queue, tail,
`ifdef PIQ_HIT_IDX_EN
    output hit_idx,
`endif
    output pressed_lvl_in_queue, out_valid
  );
endinterface

// File: rtl/pressed_lvl_in_queue_check.sv
// Reports whether a pressed floor level already sits in a valid slot of the
// pending-request queue. Optional lowest-match index output: PIQ_HIT_IDX_EN.
module pressed_lvl_in_queue_check #(
  parameter int DEPTH  = 4,
  parameter int LVL_W  = 2,
  parameter int TAIL_W = 3,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input logic                          clk,
  input logic                          rst_n,
  pressed_lvl_in_queue_check_if.slave  bus
);

  logic [TAIL_W-1:0] eff_tail;
  logic [DEPTH-1:0]  slot_eq;
  logic [DEPTH-1:0]  slot_live;
  logic [DEPTH-1:0]  match;
  logic              hit;
  logic              result_q;
  logic              valid_q;

  // Out-of-range tail is clamped to a full queue rather than flagged.
  always_comb begin
    eff_tail = bus.tail;
    if (bus.tail > TAIL_W'(DEPTH)) eff_tail = TAIL_W'(DEPTH);
  end

  // Slots at or past the tail may hold stale shifted data and never count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign slot_eq[gi]   = (bus.queue[gi*LVL_W +: LVL_W] == bus.pressed_lvl);
    assign slot_live[gi] = (TAIL_W'(gi) < eff_tail);
  end

  assign match = slot_eq & slot_live;
  assign hit   = |match;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= 1'b0;
      valid_q  <= 1'b0;
    end else if (bus.in_valid) begin
      result_q <= hit;
      valid_q  <= 1'b1;
    end else begin
      valid_q  <= 1'b0;
    end
  end

  assign bus.pressed_lvl_in_queue = result_q;
  assign bus.out_valid            = valid_q;

`ifdef PIQ_HIT_IDX_EN
  logic [IDX_W-1:0] hit_idx_nxt;
  logic [IDX_W-1:0] hit_idx_q;

  // Scan high to low so the lowest matching slot is the one left standing.
  always_comb begin
    hit_idx_nxt = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) hit_idx_nxt = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_idx_q <= '0;
    end else if (bus.in_valid) begin
      hit_idx_q <= hit_idx_nxt;
    end
  end

  assign bus.hit_idx = hit_idx_q;
`endif

endmodule

// File: tb/tb_pressed_lvl_in_queue_check.sv
// Directed bench for pressed_lvl_in_queue_check; build with +define+PIQ_HIT_IDX_EN
// to also check hit_idx.
module tb_pressed_lvl_in_queue_check;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = 2;
  localparam int TAIL_W = 3;
  localparam int IDX_W  = 2;
  localparam int W      = 1 + IDX_W;

  localparam logic [1:0] LA = 2'd0;
  localparam logic [1:0] LB = 2'd1;
  localparam logic [1:0] LC = 2'd2;
  localparam logic [1:0] LD = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pressed_lvl_in_queue_check_if #(.DEPTH(DEPTH), .LVL_W(LVL_W), .TAIL_W(TAIL_W), .IDX_W(IDX_W)) bus ();

  pressed_lvl_in_queue_check #(.DEPTH(DEPTH), .LVL_W(LVL_W), .TAIL_W(TAIL_W), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   tests = 0;
  int   fails = 0;
  logic check_en = 1'b0;

  // Hand-computed {hit, idx} for each accepted request, oldest first.
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  logic         exp_valid;
  logic [W-1:0] exp_res;

  function automatic logic [DEPTH*LVL_W-1:0] pack4(input logic [1:0] s0, s1, s2, s3);
    return {s3, s2, s1, s0};
  endfunction

  // First valid slot holding the level wins; only min(tail, DEPTH) slots are searched.
  function automatic logic [W-1:0] ref_result(input logic [LVL_W-1:0] lvl,
                                              input logic [DEPTH*LVL_W-1:0] q,
                                              input logic [TAIL_W-1:0] t);
    int n;
    n = (int'(t) > DEPTH) ? DEPTH : int'(t);
    for (int i = 0; i < n; i++) begin
      if (q[i*LVL_W +: LVL_W] == lvl) return {1'b1, IDX_W'(i)};
    end
    return '0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_valid <= 1'b0;
      exp_res   <= '0;
    end else if (bus.in_valid) begin
      exp_valid <= 1'b1;
      exp_res   <= ref_result(bus.pressed_lvl, bus.queue, bus.tail);
    end else begin
      exp_valid <= 1'b0;
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic [W-1:0] lit;
    if (check_en) begin
      tests++;
      if (bus.out_valid !== exp_valid) begin
        fails++;
        $display("FAIL out_valid: got %b want %b at %0t", bus.out_valid, exp_valid, $time);
      end
      tests++;
      if (bus.pressed_lvl_in_queue !== exp_res[W-1]) begin
        fails++;
        $display("FAIL result: got %b want %b at %0t", bus.pressed_lvl_in_queue, exp_res[W-1], $time);
      end
`ifdef PIQ_HIT_IDX_EN
      tests++;
      if (bus.hit_idx !== exp_res[IDX_W-1:0]) begin
        fails++;
        $display("FAIL hit_idx: got %0d want %0d at %0t", bus.hit_idx, exp_res[IDX_W-1:0], $time);
      end
`endif
      if (exp_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL literal_q: got empty queue want an entry at %0t", $time);
        end else begin
          lit = exp_q.pop_front();
          tests++;
          if (exp_res !== lit) begin
            fails++;
            $display("FAIL model_pin: got %b want %b at %0t", exp_res, lit, $time);
          end
          tests++;
          if (bus.pressed_lvl_in_queue !== lit[W-1]) begin
            fails++;
            $display("FAIL literal_result: got %b want %b at %0t", bus.pressed_lvl_in_queue, lit[W-1], $time);
          end
`ifdef PIQ_HIT_IDX_EN
          tests++;
          if (bus.hit_idx !== lit[IDX_W-1:0]) begin
            fails++;
            $display("FAIL literal_idx: got %0d want %0d at %0t", bus.hit_idx, lit[IDX_W-1:0], $time);
          end
`endif
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] lvl, input logic [DEPTH*LVL_W-1:0] q,
                      input logic [TAIL_W-1:0] t, input logic hit, input logic [IDX_W-1:0] idx);
    @(negedge clk);
    rst_n           = 1'b1;
    bus.in_valid    = 1'b1;
    bus.pressed_lvl = lvl;
    bus.queue       = q;
    bus.tail        = t;
    exp_q.push_back({hit, idx});
  endtask

  task automatic idle();
    @(negedge clk);
    rst_n           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.pressed_lvl = LVL_W'($urandom_range(0, 3));
    bus.queue       = (DEPTH*LVL_W)'($urandom);
    bus.tail        = TAIL_W'($urandom_range(0, 7));
  endtask

  task automatic expect_zero(input string name);
    tests++;
    if (bus.out_valid !== 1'b0 || bus.pressed_lvl_in_queue !== 1'b0) begin
      fails++;
      $display("FAIL %s: got valid=%b result=%b want 0/0", name, bus.out_valid, bus.pressed_lvl_in_queue);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.pressed_lvl = '0;
    bus.queue       = '0;
    bus.tail        = '0;

    @(posedge clk);
    #1 check_en = 1'b1;
    @(posedge clk);
    #1 expect_zero("reset_state");

    send(LB, pack4(LA, LB, LC, LD), 3'd4, 1'b1, 2'd1);  // plain hit
    send(LD, pack4(LA, LB, LC, LC), 3'd3, 1'b0, 2'd0);  // miss, stale dup past tail
    send(LD, pack4(LA, LB, LC, LD), 3'd3, 1'b0, 2'd0);  // match just beyond tail
    send(LD, pack4(LA, LB, LC, LD), 3'd4, 1'b1, 2'd3);  // same, now inside tail
    send(LA, pack4(LA, LB, LC, LD), 3'd0, 1'b0, 2'd0);  // empty queue
    send(LD, pack4(LA, LB, LC, LD), 3'd7, 1'b1, 2'd3);  // tail clamped to 4
    send(LC, pack4(LC, LC, LC, LC), 3'd4, 1'b1, 2'd0);  // duplicates, lowest index

    // Alternating valid: results must hold across the idle cycles.
    idle();
    send(LA, pack4(LA, LB, LC, LD), 3'd1, 1'b1, 2'd0);
    idle();
    send(LC, pack4(LA, LB, LC, LD), 3'd2, 1'b0, 2'd0);
    idle();
    idle();

    send(LC, pack4(LD, LD, LC, LA), 3'd4, 1'b1, 2'd2);
    send(LA, pack4(LD, LD, LC, LA), 3'd4, 1'b1, 2'd3);
    send(LA, pack4(LD, LD, LC, LA), 3'd3, 1'b0, 2'd0);
    send(LB, pack4(LB, LA, LB, LA), 3'd5, 1'b1, 2'd0);

    // Reset wins over a would-be hit presented in the same cycle.
    @(negedge clk);
    rst_n           = 1'b0;
    bus.in_valid    = 1'b1;
    bus.pressed_lvl = LB;
    bus.queue       = pack4(LA, LB, LC, LD);
    bus.tail        = 3'd4;
    @(posedge clk);
    #1 expect_zero("reset_over_valid");

    idle();
    send(LD, pack4(LD, LA, LA, LA), 3'd2, 1'b1, 2'd0);
    idle();
    idle();
    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
